// File: rtl/alu_seq.sv
// alu_seq: registered, slice-serial Z80-style ALU with valid/ready handshakes.
// Slice 0 is computed on the accept edge from the live inputs. The remaining
// slices are computed from latched operands, one per clock, LSB first.
// Shifts are produced full-width on the accept edge.
module alu_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  input  logic             c_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic [7:0]       flags,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SBC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_CP  = 4'd7;
  localparam logic [3:0] OP_INC = 4'd8;
  localparam logic [3:0] OP_DEC = 4'd9;
  localparam logic [3:0] OP_NEG = 4'd10;
  localparam logic [3:0] OP_RLC = 4'd11;
  localparam logic [3:0] OP_RRC = 4'd12;
  localparam logic [3:0] OP_SLA = 4'd13;
  localparam logic [3:0] OP_SRL = 4'd14;
  localparam logic [3:0] OP_CPL = 4'd15;

  // Parameter legality: H comes from slice 0, so a slice must cover bit 3.
  if (WIDTH % SLICE != 0) begin : g_bad_width
    $error("alu_seq: WIDTH must be a multiple of SLICE");
  end
  if (SLICE < 4) begin : g_bad_slice
    $error("alu_seq: SLICE must be at least 4");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic             cin_q, cin_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             h_q, h_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [7:0]       flags_q, flags_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic [WIDTH-1:0] cur_a, cur_b;
  logic [3:0]       cur_op;
  logic             cur_cin;
  logic [CW-1:0]    idx;
  logic [WIDTH-1:0] x_full, y_full;
  logic             ci0, sub_op, arith;
  logic [SLICE-1:0] xs, ys, slice_sum, slice_res;
  logic [SLICE:0]   cy;
  logic             c_slice;
  int unsigned      base;
  logic [WIDTH-1:0] res_full;
  logic             h_carry, last;
  logic [WIDTH-1:0] fin_out;
  logic [7:0]       fin_flags;
  logic             is_shift;
  logic [WIDTH-1:0] shift_res;
  logic             shift_c;
  logic [7:0]       shift_flags;

  assign in_ready  = in_ready_q;
  assign out       = out_q;
  assign flags     = flags_q;
  assign out_valid = out_valid_q;

  // Operand source: live inputs on the accept edge, latched copies afterwards.
  always_comb begin
    cur_a   = (state_q == S_IDLE) ? a      : a_q;
    cur_b   = (state_q == S_IDLE) ? b      : b_q;
    cur_op  = (state_q == S_IDLE) ? opcode : op_q;
    cur_cin = (state_q == S_IDLE) ? c_in   : cin_q;
    idx     = (state_q == S_IDLE) ? '0     : cnt_q;
    base    = 32'(idx) * SLICE;
    last    = (idx == CW'(NSLICE - 1));
  end

  // Map every arithmetic op onto x + y + carry; subtracts invert y and carry.
  always_comb begin
    x_full = cur_a;
    y_full = cur_b;
    ci0    = 1'b0;
    sub_op = 1'b0;
    arith  = 1'b1;
    case (cur_op)
      OP_ADD: ci0 = 1'b0;
      OP_ADC: ci0 = cur_cin;
      OP_SUB, OP_CP: begin
        y_full = ~cur_b; ci0 = 1'b1; sub_op = 1'b1;
      end
      OP_SBC: begin
        y_full = ~cur_b; ci0 = ~cur_cin; sub_op = 1'b1;
      end
      OP_INC: begin
        y_full = '0; ci0 = 1'b1;
      end
      OP_DEC: begin
        y_full = '1; ci0 = 1'b0; sub_op = 1'b1;
      end
      OP_NEG: begin
        x_full = '0; y_full = ~cur_a; ci0 = 1'b1; sub_op = 1'b1;
      end
      default: arith = 1'b0;
    endcase
  end

  // One slice of ripple-carry add plus the bitwise ops.
  always_comb begin
    xs      = x_full[base +: SLICE];
    ys      = y_full[base +: SLICE];
    c_slice = (idx == '0) ? ci0 : carry_q;
    cy      = '0;
    cy[0]   = c_slice;
    slice_sum = '0;
    for (int i = 0; i < int'(SLICE); i++) begin
      slice_sum[i] = xs[i] ^ ys[i] ^ cy[i];
      cy[i+1]      = (xs[i] & ys[i]) | (cy[i] & (xs[i] ^ ys[i]));
    end
    case (cur_op)
      OP_AND:  slice_res = xs & ys;
      OP_OR:   slice_res = xs | ys;
      OP_XOR:  slice_res = xs ^ ys;
      OP_CPL:  slice_res = ~xs;
      default: slice_res = slice_sum;
    endcase
    res_full = res_q;
    res_full[base +: SLICE] = slice_res;
    h_carry  = (idx == '0) ? cy[4] : h_q;
  end

  // Final result and flags, valid when the last slice is being processed.
  always_comb begin
    fin_out   = (cur_op == OP_CP) ? cur_a : res_full;
    fin_flags = 8'h00;
    fin_flags[7] = res_full[WIDTH-1];
    fin_flags[6] = (res_full == '0);
    if (arith) begin
      fin_flags[4] = h_carry ^ sub_op;
      fin_flags[2] = cy[SLICE] ^ cy[SLICE-1];
      fin_flags[1] = sub_op;
      fin_flags[0] = ((cur_op == OP_INC) || (cur_op == OP_DEC)) ? cur_cin
                                                                 : (cy[SLICE] ^ sub_op);
    end else begin
      fin_flags[4] = (cur_op == OP_AND) || (cur_op == OP_CPL);
      fin_flags[2] = ~^res_full;
      fin_flags[1] = (cur_op == OP_CPL);
      fin_flags[0] = 1'b0;
    end
  end

  // Full-width rotates/shifts, produced in a single clock.
  always_comb begin
    is_shift  = (cur_op >= OP_RLC) && (cur_op <= OP_SRL);
    shift_res = cur_a;
    shift_c   = 1'b0;
    case (cur_op)
      OP_RLC: begin shift_res = {cur_a[WIDTH-2:0], cur_a[WIDTH-1]}; shift_c = cur_a[WIDTH-1]; end
      OP_RRC: begin shift_res = {cur_a[0], cur_a[WIDTH-1:1]};       shift_c = cur_a[0];       end
      OP_SLA: begin shift_res = {cur_a[WIDTH-2:0], 1'b0};           shift_c = cur_a[WIDTH-1]; end
      OP_SRL: begin shift_res = {1'b0, cur_a[WIDTH-1:1]};           shift_c = cur_a[0];       end
      default: ;
    endcase
    shift_flags = {shift_res[WIDTH-1], (shift_res == '0), 1'b0, 1'b0, 1'b0,
                   ~^shift_res, 1'b0, shift_c};
  end

  // Next-state and register updates for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    cin_d       = cin_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    h_d         = h_q;
    res_d       = res_q;
    out_d       = out_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d   = a;
          b_d   = b;
          op_d  = opcode;
          cin_d = c_in;
          if (is_shift) begin
            out_d       = shift_res;
            flags_d     = shift_flags;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            res_d   = res_full;
            carry_d = cy[SLICE];
            h_d     = cy[4];
            if (last) begin
              out_d       = fin_out;
              flags_d     = fin_flags;
              out_valid_d = 1'b1;
              cnt_d       = '0;
              state_d     = S_DONE;
            end else begin
              cnt_d   = CW'(1);
              state_d = S_RUN;
            end
          end
        end
      end
      S_RUN: begin
        res_d   = res_full;
        carry_d = cy[SLICE];
        if (last) begin
          out_d       = fin_out;
          flags_d     = fin_flags;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers; reset discards any op in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      cin_q       <= 1'b0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      h_q         <= 1'b0;
      res_q       <= '0;
      out_q       <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      cin_q       <= cin_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      h_q         <= h_d;
      res_q       <= res_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, backpressure/reset sequences and
// randomized ops against an arithmetic reference model, on 8- and 16-bit builds.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a_s, b_s;
  logic [3:0]  op_s;
  logic        cin_s;
  logic        iv8, iv16, out_ready;
  logic        ir8, ov8, ir16, ov16;
  logic [7:0]  out8, fl8, fl16;
  logic [15:0] out16;
  logic        sel;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8), .SLICE(4)) u8 (
    .clk(clk), .rst(rst), .a(a_s[7:0]), .b(b_s[7:0]), .opcode(op_s), .c_in(cin_s),
    .in_valid(iv8), .in_ready(ir8), .out(out8), .flags(fl8), .out_valid(ov8),
    .out_ready(out_ready));

  alu_seq #(.WIDTH(16), .SLICE(4)) u16 (
    .clk(clk), .rst(rst), .a(a_s), .b(b_s), .opcode(op_s), .c_in(cin_s),
    .in_valid(iv16), .in_ready(ir16), .out(out16), .flags(fl16), .out_valid(ov16),
    .out_ready(out_ready));

  logic [15:0] d_out;
  logic [7:0]  d_fl;
  logic        d_ov, d_ir;
  assign d_out = sel ? out16 : {8'h00, out8};
  assign d_fl  = sel ? fl16  : fl8;
  assign d_ov  = sel ? ov16  : ov8;
  assign d_ir  = sel ? ir16  : ir8;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: Z80 flag rules computed with plain integer arithmetic.
  function automatic logic [23:0] model(input int w, input logic [3:0] op,
                                        input int a, input int b, input logic cin);
    int mask, msb, r, ci, o;
    logic s, z, h, pv, n, c, plog;
    mask = (1 << w) - 1;
    msb  = 1 << (w - 1);
    ci   = cin ? 1 : 0;
    h = 0; pv = 0; n = 0; c = 0; plog = 1; r = 0;
    case (op)
      4'd0, 4'd1: begin
        if (op == 4'd0) ci = 0;
        r = a + b + ci; c = (r > mask); h = ((a & 15) + (b & 15) + ci) > 15;
        pv = ((a ^ r) & (b ^ r) & msb) != 0; plog = 0;
      end
      4'd2, 4'd3, 4'd7: begin
        if (op != 4'd3) ci = 0;
        r = a - b - ci; c = (r < 0); h = ((a & 15) - (b & 15) - ci) < 0;
        pv = ((a ^ b) & (a ^ r) & msb) != 0; n = 1; plog = 0;
      end
      4'd8:  begin r = a + 1; h = (a & 15) == 15; pv = (a == msb - 1); c = cin; plog = 0; end
      4'd9:  begin r = a - 1; h = (a & 15) == 0; pv = (a == msb); c = cin; n = 1; plog = 0; end
      4'd10: begin r = -a; h = (a & 15) != 0; pv = (a == msb); c = (a != 0); n = 1; plog = 0; end
      4'd4:  begin r = a & b; h = 1; end
      4'd5:  r = a | b;
      4'd6:  r = a ^ b;
      4'd11: begin r = (a << 1) | (a >> (w - 1)); c = (a & msb) != 0; end
      4'd12: begin r = (a >> 1) | ((a & 1) << (w - 1)); c = a & 1; end
      4'd13: begin r = a << 1; c = (a & msb) != 0; end
      4'd14: begin r = a >> 1; c = a & 1; end
      default: begin r = ~a; h = 1; n = 1; end
    endcase
    r = r & mask;
    if (plog) pv = ($countones(r) % 2) == 0;
    s = (r & msb) != 0;
    z = (r == 0);
    o = (op == 4'd7) ? a : r;
    return {16'(o), s, z, 1'b0, h, 1'b0, pv, n, c};
  endfunction

  // Issue one op, wait for the result (bounded), optionally stall the consumer.
  task automatic run_op(input logic s16, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic cin, input int hold,
                        output logic [15:0] got_out, output logic [7:0] got_fl,
                        output int lat);
    int guard;
    sel = s16;
    guard = 0;
    @(negedge clk);
    while (!d_ir && guard < 50) begin @(negedge clk); guard++; end
    chk("in_ready_idle", 32'(d_ir), 32'd1);
    a_s = a; b_s = b; op_s = op; cin_s = cin;
    if (s16) iv16 = 1'b1; else iv8 = 1'b1;
    @(posedge clk);
    #1;
    iv8 = 1'b0; iv16 = 1'b0;
    a_s = 16'($urandom); b_s = 16'($urandom); op_s = 4'($urandom); cin_s = 1'($urandom);
    lat = 1;
    @(negedge clk);
    while (!d_ov && lat < 50) begin @(negedge clk); lat++; end
    got_out = d_out;
    got_fl  = d_fl;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_out",   32'(d_out), 32'(got_out));
      chk("hold_flags", 32'(d_fl),  32'(got_fl));
      chk("hold_valid", 32'(d_ov),  32'd1);
      chk("hold_ready", 32'(d_ir),  32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_valid", 32'(d_ov), 32'd0);
    chk("release_ready", 32'(d_ir), 32'd1);
  endtask

  typedef struct {
    logic        s16;
    logic [3:0]  op;
    logic [15:0] a, b;
    logic        cin;
    int          hold;
    logic [15:0] eo;
    logic [7:0]  ef;
    int          el;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [15:0] go;
    logic [7:0]  gf;
    logic [23:0] m;
    int lat, w, mask;
    logic        rs;
    logic [3:0]  rop;
    logic [15:0] ra, rb;
    logic        rc;

    vecs.push_back('{1'b0, 4'd0,  16'h07,   16'h07,   1'b0, 0, 16'h0E,   8'h00, 2});
    vecs.push_back('{1'b0, 4'd2,  16'h00,   16'h01,   1'b0, 0, 16'hFF,   8'h93, 2});
    vecs.push_back('{1'b0, 4'd7,  16'h00,   16'h01,   1'b0, 0, 16'h00,   8'h93, 2});
    vecs.push_back('{1'b0, 4'd0,  16'h7F,   16'h01,   1'b0, 0, 16'h80,   8'h94, 2});
    vecs.push_back('{1'b0, 4'd4,  16'hCB,   16'h2B,   1'b0, 5, 16'h0B,   8'h10, 2});
    vecs.push_back('{1'b0, 4'd14, 16'h01,   16'h00,   1'b0, 0, 16'h00,   8'h45, 1});
    vecs.push_back('{1'b0, 4'd11, 16'h80,   16'h00,   1'b0, 3, 16'h01,   8'h01, 1});
    vecs.push_back('{1'b0, 4'd8,  16'hFF,   16'h00,   1'b1, 0, 16'h00,   8'h51, 2});
    vecs.push_back('{1'b0, 4'd9,  16'h80,   16'h00,   1'b0, 0, 16'h7F,   8'h16, 2});
    vecs.push_back('{1'b0, 4'd10, 16'h01,   16'h00,   1'b0, 0, 16'hFF,   8'h93, 2});
    vecs.push_back('{1'b0, 4'd15, 16'h55,   16'h00,   1'b0, 0, 16'hAA,   8'h96, 2});
    vecs.push_back('{1'b0, 4'd6,  16'hFF,   16'hFF,   1'b0, 0, 16'h00,   8'h44, 2});
    vecs.push_back('{1'b0, 4'd3,  16'h10,   16'h0F,   1'b1, 0, 16'h00,   8'h52, 2});
    vecs.push_back('{1'b1, 4'd1,  16'h0FFF, 16'h0001, 1'b1, 0, 16'h1001, 8'h10, 4});

    sel = 1'b0;
    rst = 1'b1;
    iv8 = 1'b0; iv16 = 1'b0; out_ready = 1'b0;
    a_s = '0; b_s = '0; op_s = '0; cin_s = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out",       32'(out8),  32'd0);
    chk("rst_flags",     32'(fl8),   32'd0);
    chk("rst_valid",     32'(ov8),   32'd0);
    chk("rst_ready",     32'(ir8),   32'd1);
    chk("rst_ready16",   32'(ir16),  32'd1);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].s16, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].hold,
             go, gf, lat);
      chk($sformatf("vec%0d_out", i),   32'(go),  32'(vecs[i].eo));
      chk($sformatf("vec%0d_flags", i), 32'(gf),  32'(vecs[i].ef));
      chk($sformatf("vec%0d_lat", i),   32'(lat), 32'(vecs[i].el));
    end

    // Reset asserted while the 16-bit unit is mid-RUN.
    sel = 1'b1;
    @(negedge clk);
    a_s = 16'h1234; b_s = 16'h1111; op_s = 4'd0; cin_s = 1'b0; iv16 = 1'b1;
    @(posedge clk);
    #1 iv16 = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrun_rst_out",   32'(out16), 32'd0);
    chk("midrun_rst_flags", 32'(fl16),  32'd0);
    chk("midrun_rst_valid", 32'(ov16),  32'd0);
    chk("midrun_rst_ready", 32'(ir16),  32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b1, 4'd2, 16'h8000, 16'h0001, 1'b0, 0, go, gf, lat);
    m = model(16, 4'd2, 32'h8000, 32'h0001, 1'b0);
    chk("post_rst_out",   32'(go),  32'(m[23:8]));
    chk("post_rst_flags", 32'(gf),  32'(m[7:0]));
    chk("post_rst_lat",   32'(lat), 32'd4);

    // Randomized ops on both builds against the reference model.
    for (int k = 0; k < 80; k++) begin
      rs   = 1'($urandom);
      w    = rs ? 16 : 8;
      mask = (1 << w) - 1;
      rop  = 4'($urandom);
      ra   = 16'($urandom & mask);
      rb   = 16'($urandom & mask);
      if (k % 10 == 0) rb = ra;
      rc   = 1'($urandom);
      run_op(rs, rop, ra, rb, rc, (k % 7 == 0) ? 2 : 0, go, gf, lat);
      m = model(w, rop, int'(ra), int'(rb), rc);
      chk($sformatf("rnd%0d_op%0d_out", k, rop),   32'(go),  32'(m[23:8]));
      chk($sformatf("rnd%0d_op%0d_flags", k, rop), 32'(gf),  32'(m[7:0]));
      chk($sformatf("rnd%0d_op%0d_lat", k, rop),   32'(lat),
          (rop >= 4'd11 && rop <= 4'd14) ? 32'd1 : 32'(w / 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
